// File: rtl/aoi_pkg.sv
// Shared types and constants for the AOI cell self-test.
package aoi_pkg;

    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned VEC_W       = 4;
    localparam int unsigned CNT_W       = 4;

    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/aoi.sv
// 4-input AND-OR-INVERT gate cell: y = ~((a & b) | (c & d)).
module aoi (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    // Pure combinational cell function.
    assign y = ~((a & b) | (c & d));

endmodule

// File: rtl/aoi_bist.sv
// Self-test driver/checker: sweeps all 16 vectors into an AOI cell and logs mismatches.
module aoi_bist
    import aoi_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [VEC_W-1:0] vec_o,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_vld
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [VEC_W-1:0]   vec_nxt;
    logic [VEC_W-1:0]   ffv_nxt;
    logic [ERR_W-1:0]   err_nxt;
    logic               busy_nxt, done_nxt, pass_nxt, ffvld_nxt;
    logic               exp_y;
    logic               mismatch;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // Golden reference: a known-good cell driven by the same vector.
    aoi u_golden (
        .a (vec_o[3]),
        .b (vec_o[2]),
        .c (vec_o[1]),
        .d (vec_o[0]),
        .y (exp_y)
    );

    assign mismatch = (y_i != exp_y);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vec_nxt   = vec_o;
        err_nxt   = err_count;
        ffv_nxt   = first_fail_vec;
        ffvld_nxt = first_fail_vld;
        busy_nxt  = busy;
        done_nxt  = done;
        pass_nxt  = pass;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                    vec_nxt   = '0;
                    err_nxt   = '0;
                    ffvld_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_nxt = err_count + ERR_W'(1);
                    if (!first_fail_vld) begin
                        ffv_nxt   = vec_o;
                        ffvld_nxt = 1'b1;
                    end
                end
                if (vec_o != VEC_LAST) begin
                    vec_nxt   = vec_o + VEC_W'(1);
                    cnt_nxt   = '0;
                    state_nxt = SETTLE;
                end else begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == '0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            vec_o          <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            vec_o          <= vec_nxt;
            err_count      <= err_nxt;
            first_fail_vec <= ffv_nxt;
            first_fail_vld <= ffvld_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_aoi_bist.sv
// Bench for aoi_bist: directed sweeps with a scoreboard of hand-computed results.
module tb_aoi_bist;

    localparam int unsigned ERR_W = 5;
    localparam int          SWEEP_CYCLES = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       vec_o;
    logic             y_i;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       first_fail_vec;
    logic             first_fail_vld;

    logic [1:0]       mode;   // 0 good, 1 stuck-0, 2 stuck-1, 3 inverted
    logic             good_y;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [ERR_W-1:0] err;
        logic [3:0]       ffv;
        logic             ffvld;
        logic             pass;
        int               due;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    aoi_bist #(.SETTLE_CYCLES(1), .ERR_W(ERR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .vec_o          (vec_o),
        .y_i            (y_i),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_vec (first_fail_vec),
        .first_fail_vld (first_fail_vld)
    );

    aoi u_cut (
        .a (vec_o[3]),
        .b (vec_o[2]),
        .c (vec_o[1]),
        .d (vec_o[0]),
        .y (good_y)
    );

    always_comb begin
        case (mode)
            2'd0:    y_i = good_y;
            2'd1:    y_i = 1'b0;
            2'd2:    y_i = 1'b1;
            default: y_i = ~good_y;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on each rising done, pop the oldest expectation and compare.
    logic done_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done && !done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("done_latency", 32'(cyc), 32'(e.due));
                chk("err_count",    32'(err_count), 32'(e.err));
                chk("ff_vld",       32'(first_fail_vld), 32'(e.ffvld));
                if (e.ffvld) chk("ff_vec", 32'(first_fail_vec), 32'(e.ffv));
                chk("pass",         32'(pass), 32'(e.pass));
                chk("busy_in_done", 32'(busy), 32'(0));
                chk("vec_in_done",  32'(vec_o), 32'(4'hF));
            end
        end
        done_q = done;
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_vec"},   32'(vec_o), 32'(0));
        chk({tag, "_busy"},  32'(busy), 32'(0));
        chk({tag, "_done"},  32'(done), 32'(0));
        chk({tag, "_pass"},  32'(pass), 32'(0));
        chk({tag, "_err"},   32'(err_count), 32'(0));
        chk({tag, "_ffv"},   32'(first_fail_vec), 32'(0));
        chk({tag, "_ffvld"}, 32'(first_fail_vld), 32'(0));
    endtask

    // Pulse start for one cycle, check the accept-edge effects, optionally queue the expected result.
    task automatic issue(input logic [1:0] m, input bit push, input logic [ERR_W-1:0] e_err,
                         input logic [3:0] e_ffv, input logic e_ffvld, input logic e_pass);
        exp_t e;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy",  32'(busy), 32'(1));
        chk("accept_done",  32'(done), 32'(0));
        chk("accept_err",   32'(err_count), 32'(0));
        chk("accept_ffvld", 32'(first_fail_vld), 32'(0));
        chk("accept_vec",   32'(vec_o), 32'(0));
        if (push) begin
            e.err   = e_err;
            e.ffv   = e_ffv;
            e.ffvld = e_ffvld;
            e.pass  = e_pass;
            e.due   = cyc + SWEEP_CYCLES;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("sweep_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Good cell: clean pass.
        issue(2'd0, 1'b1, 5'd0, 4'h0, 1'b0, 1'b1);
        wait_drain();
        chk("idle_after_done", 32'(done), 32'(1));

        // Stuck-at-0: the 9 vectors whose good output is 1 fail, first at 0000.
        issue(2'd1, 1'b1, 5'd9, 4'h0, 1'b1, 1'b0);
        wait_drain();

        // Stuck-at-1: the 7 vectors whose good output is 0 fail, first at 0011.
        issue(2'd2, 1'b1, 5'd7, 4'h3, 1'b1, 1'b0);
        wait_drain();

        // Inverted output: every vector fails, count reaches 16.
        issue(2'd3, 1'b1, 5'd16, 4'h0, 1'b1, 1'b0);
        wait_drain();

        // Start re-pulsed mid-sweep must not disturb timing or results.
        issue(2'd1, 1'b1, 5'd9, 4'h0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_midsweep", 32'(busy), 32'(1));
        wait_drain();

        // Start from DONE with stale errors: accept edge clears them, then a clean pass.
        issue(2'd0, 1'b1, 5'd0, 4'h0, 1'b0, 1'b1);
        wait_drain();

        // Asynchronous reset when vec_o reaches 6, then a fresh sweep.
        issue(2'd1, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0);
        begin
            int n = 0;
            while (vec_o != 4'h6 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("reach_vec6", 32'(vec_o), 32'(6));
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'd0, 1'b1, 5'd0, 4'h0, 1'b0, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
